fetch_stage: RTL and testbench

Instruction-fetch stage of the RV64 core, directly upstream of the instruction memory and downstream of the execute and CSR/trap logic. It owns the program counter and drives `pc_addr` to the instruction memory. It captures the returned instruction and any fetch exception into the IF/ID pipeline register. It also handles stall, branch/jump redirect and trap redirect, and freezes fetch after a fetch fault until the trap is taken.

---
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/instruction-memory port, control redirects and the IF/ID payload.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CODE_W = 4;

    logic              stall;
    logic              redirect_en;
    logic [XLEN-1:0]   redirect_pc;
    logic              trap_en;
    logic [XLEN-1:0]   trap_pc;

    logic [XLEN-1:0]   pc_addr;
    logic [ILEN-1:0]   imem_instr;
    logic              imem_exc_en;
    logic [CODE_W-1:0] imem_exc_code;
    logic [XLEN-1:0]   imem_exc_val;

    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [ILEN-1:0]   if_instr;
    logic              if_exc_en;
    logic [CODE_W-1:0] if_exc_code;
    logic [XLEN-1:0]   if_exc_val;

    modport master (
        input  stall, redirect_en, redirect_pc, trap_en, trap_pc,
        input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        output pc_addr,
        output if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val
    );

    modport slave (
        output stall, redirect_en, redirect_pc, trap_en, trap_pc,
        output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        input  pc_addr,
        input  if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val
    );
endinterface

// File: rtl/fetch_stage.sv
// RV64 instruction-fetch stage: owns the PC, fills IF/ID, handles stall/redirect/trap
// and freezes fetch after a fetch fault until the trap redirect arrives.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CODE_W = 4;
    localparam logic [ILEN-1:0]   NOP_INSTR     = 32'h0000_0013;
    localparam logic [CODE_W-1:0] CAUSE_MISALGN = 4'd0;

    typedef enum logic {FETCH, WAIT_TRAP} state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              if_valid_q;
    logic [XLEN-1:0]   if_pc_q;
    logic [ILEN-1:0]   if_instr_q;
    logic              if_exc_en_q;
    logic [CODE_W-1:0] if_exc_code_q;
    logic [XLEN-1:0]   if_exc_val_q;

    logic              exc_en_c;
    logic [CODE_W-1:0] exc_code_c;
    logic [XLEN-1:0]   exc_val_c;
    logic              redirect_c;

    // Fetch exception select: misalignment outranks the memory's own fault.
    always_comb begin
        exc_en_c   = 1'b0;
        exc_code_c = '0;
        exc_val_c  = '0;
        if (pc_q[1:0] != 2'b00) begin
            exc_en_c   = 1'b1;
            exc_code_c = CAUSE_MISALGN;
            exc_val_c  = pc_q;
        end else if (bus.imem_exc_en) begin
            exc_en_c   = 1'b1;
            exc_code_c = bus.imem_exc_code;
            exc_val_c  = bus.imem_exc_val;
        end
    end

    // A branch redirect is only honoured while fetching normally.
    assign redirect_c = bus.redirect_en && (state_q == FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= RESET_PC;
            if_instr_q    <= NOP_INSTR;
            if_exc_en_q   <= 1'b0;
            if_exc_code_q <= '0;
            if_exc_val_q  <= '0;
        end else begin
            // Next PC; the faulting PC is held so it stays frozen until the trap.
            if (bus.trap_en) begin
                pc_q    <= bus.trap_pc;
                state_q <= FETCH;
            end else if (redirect_c) begin
                pc_q <= bus.redirect_pc;
            end else if (bus.stall || state_q == WAIT_TRAP || exc_en_c) begin
                pc_q <= pc_q;
            end else begin
                pc_q <= pc_q + XLEN'(4);
            end

            // IF/ID slot: flush beats stall, WAIT_TRAP emits bubbles.
            if (bus.trap_en || redirect_c || (!bus.stall && state_q == WAIT_TRAP)) begin
                if_valid_q    <= 1'b0;
                if_pc_q       <= pc_q;
                if_instr_q    <= NOP_INSTR;
                if_exc_en_q   <= 1'b0;
                if_exc_code_q <= '0;
                if_exc_val_q  <= '0;
            end else if (!bus.stall) begin
                if_valid_q    <= 1'b1;
                if_pc_q       <= pc_q;
                if_instr_q    <= exc_en_c ? NOP_INSTR : bus.imem_instr;
                if_exc_en_q   <= exc_en_c;
                if_exc_code_q <= exc_code_c;
                if_exc_val_q  <= exc_val_c;
                if (exc_en_c) state_q <= WAIT_TRAP;
            end
        end
    end

    assign bus.pc_addr     = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_exc_en   = if_exc_en_q;
    assign bus.if_exc_code = if_exc_code_q;
    assign bus.if_exc_val  = if_exc_val_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table through a scoreboard queue, then a random-stall
// stream and a bounded wait on a redirected fetch.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exc_gate = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_stage_if bus ();
    fetch_stage #(.RESET_PC(64'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        if (pc == 64'h0) return 32'h0010_0093;
        if (pc == 64'h4) return 32'h0020_0113;
        return {pc[19:0], 12'h0B3};
    endfunction

    // Memory model: combinational word, faults at/above 0x2000 when the gate is open.
    always_comb begin
        bus.imem_instr    = instr_of(bus.pc_addr);
        bus.imem_exc_en   = exc_gate && (bus.pc_addr >= 64'h2000);
        bus.imem_exc_code = 4'd1;
        bus.imem_exc_val  = bus.pc_addr;
    end

    typedef struct {
        logic        rst, stall, red_en, trap_en, gate;
        logic [63:0] red_pc, trap_pc;
        logic [63:0] e_pc_addr;
        logic        e_valid;
        logic [63:0] e_if_pc;
        logic [31:0] e_instr;
        logic        e_exc;
        logic [3:0]  e_code;
        logic [63:0] e_val;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    // kind: 0 bubble, 1 instruction, 2 fault (val = if_pc)
    function automatic vec_t v(input logic r, input logic st, input logic re, input logic [63:0] rpc,
                               input logic te, input logic [63:0] tpc, input logic g,
                               input logic [63:0] epc, input int kind, input logic [63:0] eifpc,
                               input logic [3:0] code);
        vec_t x;
        x.rst = r; x.stall = st; x.red_en = re; x.red_pc = rpc;
        x.trap_en = te; x.trap_pc = tpc; x.gate = g;
        x.e_pc_addr = epc;
        x.e_valid = (kind != 0);
        x.e_if_pc = eifpc;
        x.e_instr = (kind == 1) ? instr_of(eifpc) : 32'h0000_0013;
        x.e_exc   = (kind == 2);
        x.e_code  = (kind == 2) ? code : 4'd0;
        x.e_val   = (kind == 2) ? eifpc : 64'd0;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input string tag, input vec_t e);
        check({tag, ".pc_addr"}, bus.pc_addr, e.e_pc_addr);
        check({tag, ".if_valid"}, 64'(bus.if_valid), 64'(e.e_valid));
        check({tag, ".if_pc"}, bus.if_pc, e.e_if_pc);
        check({tag, ".if_instr"}, 64'(bus.if_instr), 64'(e.e_instr));
        check({tag, ".if_exc_en"}, 64'(bus.if_exc_en), 64'(e.e_exc));
        check({tag, ".if_exc_code"}, 64'(bus.if_exc_code), 64'(e.e_code));
        check({tag, ".if_exc_val"}, bus.if_exc_val, e.e_val);
    endtask

    task automatic drive_idle();
        rst = 1'b0; exc_gate = 1'b0;
        bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
        bus.trap_en = 1'b0; bus.trap_pc = '0;
    endtask

    initial begin
        vec_t e;
        logic [63:0] model_pc;
        logic [63:0] last_if_pc;
        logic [63:0] q_pc[$];
        logic        got;

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_row("reset", v(1,0,0,0,0,0,0, 64'h0, 0, 64'h0, 0));

        // rst st re rpc te tpc g | pc_addr kind if_pc code
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h4,   1, 64'h0,   0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h8,   1, 64'h4,   0));
        vecs.push_back(v(0,1,0,0,0,0,0, 64'h8,   1, 64'h4,   0));
        vecs.push_back(v(0,1,0,0,0,0,0, 64'h8,   1, 64'h4,   0));
        vecs.push_back(v(0,1,0,0,0,0,0, 64'h8,   1, 64'h4,   0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'hC,   1, 64'h8,   0));
        vecs.push_back(v(0,1,1,64'h100,0,0,0, 64'h100, 0, 64'hC, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h104, 1, 64'h100, 0));
        vecs.push_back(v(0,0,1,64'h102,0,0,0, 64'h102, 0, 64'h104, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h102, 2, 64'h102, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h102, 0, 64'h102, 0));
        vecs.push_back(v(0,0,1,64'h300,0,0,0, 64'h102, 0, 64'h102, 0));
        vecs.push_back(v(0,0,0,0,1,64'h200,0, 64'h200, 0, 64'h102, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h204, 1, 64'h200, 0));
        vecs.push_back(v(0,0,1,64'h2000,0,0,0, 64'h2000, 0, 64'h204, 0));
        vecs.push_back(v(0,0,0,0,0,0,1, 64'h2000, 2, 64'h2000, 4'd1));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h2000, 0, 64'h2000, 0));
        vecs.push_back(v(0,0,0,0,0,0,1, 64'h2000, 0, 64'h2000, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h2000, 0, 64'h2000, 0));
        vecs.push_back(v(0,1,0,0,0,0,1, 64'h2000, 0, 64'h2000, 0));
        vecs.push_back(v(0,0,1,64'h40,1,64'h80,0, 64'h80, 0, 64'h2000, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h84,  1, 64'h80,  0));
        vecs.push_back(v(0,1,0,0,1,64'h400,0, 64'h400, 0, 64'h84, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h404, 1, 64'h400, 0));
        vecs.push_back(v(0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h404, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h4,   1, 64'h0,   0));
        vecs.push_back(v(1,1,1,64'h700,1,64'h900,1, 64'h0, 0, 64'h0, 0));
        vecs.push_back(v(0,0,0,0,0,0,0, 64'h4,   1, 64'h0,   0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; bus.stall = vecs[i].stall;
            bus.redirect_en = vecs[i].red_en; bus.redirect_pc = vecs[i].red_pc;
            bus.trap_en = vecs[i].trap_en; bus.trap_pc = vecs[i].trap_pc;
            exc_gate = vecs[i].gate;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_row($sformatf("vec%0d", i), e);
        end

        // Random stalls: every PC reaches IF/ID exactly once, in order.
        model_pc   = 64'h4;
        last_if_pc = 64'h0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive_idle();
            bus.stall = ($urandom_range(0, 2) == 0);
            if (!bus.stall) begin
                q_pc.push_back(model_pc);
                model_pc = model_pc + 64'd4;
            end
            @(posedge clk);
            #1;
            check("stream.pc_addr", bus.pc_addr, model_pc);
            if (q_pc.size() != 0) last_if_pc = q_pc.pop_front();
            check("stream.if_pc", bus.if_pc, last_if_pc);
            check("stream.if_instr", 64'(bus.if_instr), 64'(instr_of(last_if_pc)));
        end

        // Redirect then wait (bounded) for the target to appear in IF/ID.
        @(negedge clk);
        drive_idle();
        bus.redirect_en = 1'b1; bus.redirect_pc = 64'h500;
        @(negedge clk);
        drive_idle();
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(posedge clk);
            #1;
            got = bus.if_valid;
        end
        check("redir_wait.seen", 64'(got), 64'd1);
        check("redir_wait.if_pc", bus.if_pc, 64'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
